// File: rtl/grad_pkg.sv
// Shared constants, FSM state encoding and gradient word layout for the magnitude/edge stage.
// Gradient word is {gx, gy}, both two's-complement GW bits wide.
package grad_pkg;
  localparam int NPIX = 65280;
  localparam int AW   = 16;
  localparam int GW   = 10;

  localparam int GX_MSB = 19;
  localparam int GX_LSB = 10;
  localparam int GY_MSB = 9;
  localparam int GY_LSB = 0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/grad_mag_edge_if.sv
// Memory-side bus of the magnitude stage: gradient read port and magnitude write port.
// master = the streaming engine, slave = the memories (read data returns one cycle after the address).
interface grad_mag_edge_if;
  import grad_pkg::*;

  logic            grad_rd;
  logic [AW-1:0]   grad_addr;
  logic [2*GW-1:0] grad_di;
  logic            mag_wr;
  logic [AW-1:0]   mag_addr;
  logic [7:0]      mag_do;

  modport master (output grad_rd, grad_addr, mag_wr, mag_addr, mag_do, input grad_di);
  modport slave  (input grad_rd, grad_addr, mag_wr, mag_addr, mag_do, output grad_di);
endinterface

// File: rtl/grad_l1_sat.sv
// Combinational L1 magnitude |gx|+|gy| with 8-bit saturation; zero latency, no flow control.
// Absolute values are taken as GW-bit unsigned so the most negative input maps to 2^(GW-1).
module grad_l1_sat
  import grad_pkg::*;
(
  input  logic signed [GW-1:0] gx,
  input  logic signed [GW-1:0] gy,
  output logic        [GW:0]   sum,
  output logic        [7:0]    sat8
);
  logic [GW-1:0] ax;
  logic [GW-1:0] ay;

  always_comb begin
    ax   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    sum  = {1'b0, ax} + {1'b0, ay};
    sat8 = (|sum[GW:8]) ? 8'hFF : sum[7:0];
  end
endmodule

// File: rtl/grad_mag_edge.sv
// Streams NPIX gradient words through a 2-cycle read/compute/write pipeline, one pixel per clock,
// writing saturated L1 magnitudes and counting edge pixels; no backpressure, start/done handshake only.
module grad_mag_edge
  import grad_pkg::*;
#(
  parameter int NPIX = grad_pkg::NPIX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             th,
  grad_mag_edge_if.master        bus,
  output logic [AW-1:0]          edge_cnt,
  output logic                   busy,
  output logic                   done
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t        state;
  logic [7:0]    th_lat;
  logic          drain_cnt;
  logic          p1_vld;
  logic [AW-1:0] p1_addr;
  logic [GW:0]   sum;
  logic [7:0]    sat8;
  logic          hit;

  grad_l1_sat u_l1 (
    .gx   (bus.grad_di[GX_MSB:GX_LSB]),
    .gy   (bus.grad_di[GY_MSB:GY_LSB]),
    .sum  (sum),
    .sat8 (sat8)
  );

  // Threshold compares the unsaturated sum so magnitudes above 255 still qualify.
  assign hit = p1_vld && (sum >= {3'b000, th_lat});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      th_lat        <= '0;
      drain_cnt     <= 1'b0;
      p1_vld        <= 1'b0;
      p1_addr       <= '0;
      bus.grad_rd   <= 1'b0;
      bus.grad_addr <= '0;
      bus.mag_wr    <= 1'b0;
      bus.mag_addr  <= '0;
      bus.mag_do    <= '0;
      edge_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      p1_vld     <= bus.grad_rd;
      p1_addr    <= bus.grad_addr;
      bus.mag_wr <= p1_vld;
      if (p1_vld) begin
        bus.mag_addr <= p1_addr;
        bus.mag_do   <= sat8;
      end
      if (hit) edge_cnt <= edge_cnt + AW'(1);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            th_lat        <= th;
            edge_cnt      <= '0;
            bus.grad_rd   <= 1'b1;
            bus.grad_addr <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        RUN: begin
          if (bus.grad_addr == LAST_ADDR) begin
            state       <= DRAIN;
            bus.grad_rd <= 1'b0;
            drain_cnt   <= 1'b0;
          end else begin
            bus.grad_addr <= bus.grad_addr + AW'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grad_mag_edge.sv
// Bench for grad_mag_edge: table of single-word frames, full-frame timing, mid-frame reset and back-to-back starts.
// A scoreboard queues the expected magnitude per issued read and checks each write against it.
module tb_grad_mag_edge;
  import grad_pkg::*;

  localparam int NPIX = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] th = 8'd0;
  logic [AW-1:0] edge_cnt;
  logic       busy;
  logic       done;

  grad_mag_edge_if bus ();

  grad_mag_edge #(.NPIX(NPIX)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .th       (th),
    .bus      (bus.master),
    .edge_cnt (edge_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [19:0] mem [NPIX];
  initial bus.grad_di = '0;
  always @(posedge clk) if (bus.grad_rd) bus.grad_di <= mem[bus.grad_addr[6:0]];

  typedef struct { int addr; int mag; } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails = 0;
  int th_lat = 0;
  int exp_edges = 0;
  int wr_cnt = 0;
  int first_mag = -1;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic int l1(input logic [19:0] w);
    logic signed [9:0] a, b;
    int x, y;
    a = w[19:10];
    b = w[9:0];
    x = a;
    y = b;
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    return x + y;
  endfunction

  function automatic logic [19:0] mkw(input int gx, input int gy);
    logic [9:0] a, b;
    a = gx[9:0];
    b = gy[9:0];
    return {a, b};
  endfunction

  // Scoreboard: expected result pushed when a read is issued, popped when the write appears.
  always @(negedge clk) begin
    int s;
    exp_t e;
    if (bus.grad_rd) begin
      s = l1(mem[bus.grad_addr[6:0]]);
      q.push_back('{int'(bus.grad_addr), (s > 255) ? 255 : s});
      if (s >= th_lat) exp_edges++;
    end
    if (bus.mag_wr) begin
      wr_cnt++;
      if (q.size() == 0) chk("sb_unexpected_write", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_mag_addr", bus.mag_addr, e.addr);
        chk("sb_mag_do", bus.mag_do, e.mag);
        if (bus.mag_addr == 0) first_mag = bus.mag_do;
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_grad_rd"}, bus.grad_rd, 0);
    chk({nm, "_grad_addr"}, bus.grad_addr, 0);
    chk({nm, "_mag_wr"}, bus.mag_wr, 0);
    chk({nm, "_mag_addr"}, bus.mag_addr, 0);
    chk({nm, "_mag_do"}, bus.mag_do, 0);
    chk({nm, "_edge_cnt"}, edge_cnt, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  // Leaves the bench #1 into the first RUN cycle.
  task automatic start_frame(input int t);
    th = t[7:0];
    th_lat = t;
    exp_edges = 0;
    wr_cnt = 0;
    first_mag = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_run_grad_rd", bus.grad_rd, 1);
    chk("first_run_grad_addr", bus.grad_addr, 0);
  endtask

  task automatic frame_end(input string nm, input int c0);
    int c;
    c = c0;
    while (!done && c < NPIX + 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, "_done_cycle"}, c, NPIX + 2);
    chk({nm, "_write_count"}, wr_cnt, NPIX);
    chk({nm, "_edge_cnt_model"}, edge_cnt, exp_edges);
    chk({nm, "_sb_pending"}, q.size(), 0);
  endtask

  task automatic fill(input logic [19:0] w);
    for (int i = 0; i < NPIX; i++) mem[i] = w;
  endtask

  typedef struct { int gx; int gy; int th; int mag; int hit; } vec_t;
  vec_t vt[10];

  initial begin
    int c;
    vt[0] = '{3, -4, 5, 7, 1};
    vt[1] = '{-512, -512, 255, 255, 1};
    vt[2] = '{200, 100, 255, 255, 1};
    vt[3] = '{100, 100, 201, 200, 0};
    vt[4] = '{0, 0, 1, 0, 0};
    vt[5] = '{255, 0, 255, 255, 1};
    vt[6] = '{128, 128, 255, 255, 1};
    vt[7] = '{-1, 0, 2, 1, 0};
    vt[8] = '{511, -512, 255, 255, 1};
    vt[9] = '{5, 5, 10, 10, 1};

    fill(20'h0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single interesting word at address 0, zeros elsewhere (all th >= 1, so zeros never count).
    chk("word_3_m4_encoding", mkw(3, -4), 20'h00FFC);
    chk("word_m512_encoding", mkw(-512, -512), 20'h80200);
    for (int i = 0; i < 10; i++) begin
      fill(20'h0);
      mem[0] = mkw(vt[i].gx, vt[i].gy);
      start_frame(vt[i].th);
      frame_end($sformatf("vec%0d", i), 0);
      chk($sformatf("vec%0d_mag_do", i), first_mag, vt[i].mag);
      chk($sformatf("vec%0d_edge_cnt", i), edge_cnt, vt[i].hit);
    end

    // Random frame against the model.
    for (int i = 0; i < NPIX; i++) mem[i] = 20'($urandom);
    start_frame(int'($urandom_range(0, 255)));
    frame_end("random", 0);

    // Full frame of {1,1} with th=2; start pulse mid-RUN must be ignored.
    fill(mkw(1, 1));
    start_frame(2);
    @(posedge clk); #1;
    chk("full_c1_mag_wr", bus.mag_wr, 0);
    @(posedge clk); #1;
    chk("full_c2_mag_wr", bus.mag_wr, 1);
    chk("full_c2_mag_addr", bus.mag_addr, 0);
    repeat (8) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_start_ignored_addr", bus.grad_addr, 11);
    frame_end("full", 11);
    chk("full_edge_cnt", edge_cnt, NPIX);
    chk("full_done_level", done, 1);

    // Reset asserted while address 100 is on the bus.
    start_frame(2);
    c = 0;
    while (bus.grad_addr != 100 && c < NPIX) begin @(posedge clk); #1; c++; end
    chk("reach_addr100", bus.grad_addr, 100);
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
    check_zero("midreset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle_rd", bus.grad_rd, 0);
      chk("post_reset_idle_wr", bus.mag_wr, 0);
    end
    start_frame(2);
    chk("restart_edge_cnt_zero", edge_cnt, 0);
    frame_end("restart", 0);
    chk("restart_edge_cnt", edge_cnt, NPIX);

    // start held across DONE: frame A latches th=2 (later th changes ignored), frame B re-latches th=0.
    fill(mkw(1, 1));
    th = 8'd2;
    th_lat = 2;
    exp_edges = 0;
    wr_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    th = 8'd3;
    frame_end("heldA", 5);
    chk("heldA_edge_cnt", edge_cnt, NPIX);
    fill(20'h0);
    th = 8'd0;
    th_lat = 0;
    exp_edges = 0;
    wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("heldB_busy", busy, 1);
    chk("heldB_done_low", done, 0);
    chk("heldB_edge_cnt_cleared", edge_cnt, 0);
    chk("heldB_grad_addr", bus.grad_addr, 0);
    frame_end("heldB", 0);
    chk("heldB_edge_cnt", edge_cnt, NPIX);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
